// File: rtl/reflet_reset_sequencer_if.sv
// reflet_reset_sequencer_if
// Groups the request inputs and the staged reset outputs of the Reflet reset
// sequencer. Clock and the asynchronous reset stay plain ports on the module.
//
// Signals:
//   button      raw external reset button, asynchronous, active-high
//   sw_req      software reset request, one-cycle pulse
//   wdt_req     watchdog expiry, one-cycle pulse
//   rst_mem     memory-domain reset, active-high
//   rst_periph  peripheral-domain reset, active-high
//   rst_cpu     CPU-domain reset, active-high
//   ready       high only when every domain is released
//   cause       last reset cause: 00 power/pin, 01 button, 10 software, 11 watchdog
//
// Modports:
//   master  request source / reset consumer side
//   slave   the sequencer itself
interface reflet_reset_sequencer_if;
    logic       button;
    logic       sw_req;
    logic       wdt_req;
    logic       rst_mem;
    logic       rst_periph;
    logic       rst_cpu;
    logic       ready;
    logic [1:0] cause;

    modport master (
        output button, sw_req, wdt_req,
        input  rst_mem, rst_periph, rst_cpu, ready, cause
    );

    modport slave (
        input  button, sw_req, wdt_req,
        output rst_mem, rst_periph, rst_cpu, ready, cause
    );
endinterface

// File: rtl/reflet_reset_sequencer.sv
// reflet_reset_sequencer
// Power-on and runtime reset controller. Holds all three domains in reset for
// HOLD_CYCLES, then releases memory, peripherals and CPU STAGE_CYCLES apart.
// Watchdog, software and debounced-button requests restart the sequence from
// any state and record the cause of the restart.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high (bootstrap pulse)
//   bus    reflet_reset_sequencer_if.slave (requests in, staged resets out)
//
// state      | meaning
// S_HOLD     | all domains in reset, counting HOLD_CYCLES
// S_REL_MEM  | memory released, counting STAGE_CYCLES
// S_REL_PERIPH | memory and peripherals released, counting STAGE_CYCLES
// S_RUN      | all domains released, ready asserted
module reflet_reset_sequencer #(
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_CYCLES    = 4,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    reflet_reset_sequencer_if.slave bus
);
    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_REL_MEM,
        S_REL_PERIPH,
        S_RUN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rst_mem;
    logic             r_rst_periph;
    logic             r_rst_cpu;
    logic             r_ready;
    logic [1:0]       r_cause;

    logic             r_btn_meta;
    logic             r_btn_sync;
    logic             r_btn_db;
    logic             r_btn_db_q;
    logic [DB_W-1:0]  r_db_cnt;

    logic             w_btn_rise;
    logic             w_restart;
    logic [1:0]       w_req_cause;

    // Button path: two-flop synchronizer, then a level debouncer that only
    // accepts a new level after DEBOUNCE_CYCLES consecutive disagreeing edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_btn_db   <= 1'b0;
            r_btn_db_q <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_btn_meta <= bus.button;
            r_btn_sync <= r_btn_meta;
            r_btn_db_q <= r_btn_db;
            if (r_btn_sync != r_btn_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_btn_db <= r_btn_sync;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_btn_rise  = r_btn_db & ~r_btn_db_q;
        w_restart   = bus.wdt_req | bus.sw_req | w_btn_rise;
        // Watchdog wins over software, software over button.
        w_req_cause = bus.wdt_req ? 2'b11 : (bus.sw_req ? 2'b10 : 2'b01);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_HOLD;
            r_cnt        <= '0;
            r_rst_mem    <= 1'b1;
            r_rst_periph <= 1'b1;
            r_rst_cpu    <= 1'b1;
            r_ready      <= 1'b0;
            r_cause      <= 2'b00;
        end else if (w_restart) begin
            r_state      <= S_HOLD;
            r_cnt        <= '0;
            r_rst_mem    <= 1'b1;
            r_rst_periph <= 1'b1;
            r_rst_cpu    <= 1'b1;
            r_ready      <= 1'b0;
            r_cause      <= w_req_cause;
        end else begin
            case (r_state)
                S_HOLD: begin
                    // A held button pins the count so the sequence cannot start.
                    if (r_btn_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state   <= S_REL_MEM;
                        r_cnt     <= '0;
                        r_rst_mem <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_REL_MEM: begin
                    if (r_cnt == STAGE_LAST) begin
                        r_state      <= S_REL_PERIPH;
                        r_cnt        <= '0;
                        r_rst_periph <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_REL_PERIPH: begin
                    if (r_cnt == STAGE_LAST) begin
                        r_state   <= S_RUN;
                        r_cnt     <= '0;
                        r_rst_cpu <= 1'b0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_state <= S_HOLD;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.rst_mem    = r_rst_mem;
    assign bus.rst_periph = r_rst_periph;
    assign bus.rst_cpu    = r_rst_cpu;
    assign bus.ready      = r_ready;
    assign bus.cause      = r_cause;
endmodule
